// File: rtl/intr_ctrl_if.sv
// Bundle between the interrupt controller and its peripheral/cpu side.
// slave: the controller. master: whoever drives events, mask and ack.
interface intr_ctrl_if #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned CAUSE_W = 2
);
    logic [N_SRC-1:0]   src;
    logic [N_SRC-1:0]   mask;
    logic               timer_en;
    logic               ack;
    logic               ovf_clr;
    logic               irq;
    logic [CAUSE_W-1:0] cause;
    logic [N_SRC-1:0]   pending;
    logic [N_SRC-1:0]   ovf;

    modport master (
        output src, mask, timer_en, ack, ovf_clr,
        input  irq, cause, pending, ovf
    );

    modport slave (
        input  src, mask, timer_en, ack, ovf_clr,
        output irq, cause, pending, ovf
    );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches peripheral and timer events, presents the lowest
// pending enabled source to the cpu and retires it on a rising ack edge.
module intr_ctrl #(
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned CAUSE_W      = 2,
    parameter int unsigned TIMER_PERIOD = 1000
) (
    input logic       clk,
    input logic       reset,
    intr_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMER_PERIOD);

    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

    state_e             state_q, state_d;
    logic               irq_q, irq_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   ovf_q, ovf_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               ack_q;

    logic               tick;
    logic               ack_rise;
    logic [N_SRC-1:0]   ev;
    logic [N_SRC-1:0]   clr;
    logic [N_SRC-1:0]   req;
    logic [CAUSE_W-1:0] low_idx;

    always_comb begin
        tick = bus.timer_en && (cnt_q == CntW'(TIMER_PERIOD - 1));
        if (!bus.timer_en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_comb begin
        // Timer shares the top source; a coincident external pulse is one event.
        ev            = bus.src;
        ev[N_SRC-1]   = bus.src[N_SRC-1] | tick;
        ack_rise      = bus.ack & ~ack_q;
        req           = pending_q & bus.mask;

        low_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_idx = CAUSE_W'(i);
            end
        end

        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = (state_q == StReq) && ack_rise && (cause_q == CAUSE_W'(i));
        end

        pending_d = (pending_q & ~clr) | ev;
        ovf_d     = (bus.ovf_clr ? '0 : ovf_q) | (ev & pending_q & ~clr);

        state_d = state_q;
        irq_d   = irq_q;
        cause_d = cause_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StReq;
                    irq_d   = 1'b1;
                    cause_d = low_idx;
                end else begin
                    irq_d = 1'b0;
                end
            end
            StReq: begin
                if (ack_rise) begin
                    state_d = StHold;
                    irq_d   = 1'b0;
                end
            end
            StHold: begin
                irq_d = 1'b0;
                if (!bus.ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            irq_q     <= 1'b0;
            cause_q   <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            cause_q   <= cause_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            ack_q     <= bus.ack;
        end
    end

    assign bus.irq     = irq_q;
    assign bus.cause   = cause_q;
    assign bus.pending = pending_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations, then random
// traffic, all outputs compared each cycle against a behavioural model.
module tb_intr_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned P  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    intr_ctrl_if #(.N_SRC(N), .CAUSE_W(CW)) bus ();

    intr_ctrl #(
        .N_SRC       (N),
        .CAUSE_W     (CW),
        .TIMER_PERIOD(P)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding request to the cpu, and a flag for "retired, waiting for ack release".
    int       m_cnt;
    bit       m_ack_prev;
    bit       m_busy;
    bit       m_wait_low;
    int       m_cause;
    bit [N-1:0] m_pend;
    bit [N-1:0] m_ovf;

    always @(posedge clk or negedge rst_n) begin : model
        bit         tick;
        bit         rise;
        bit [N-1:0] ev;
        bit [N-1:0] clr;
        bit [N-1:0] req;
        int         nc;
        if (!rst_n) begin
            m_cnt      <= 0;
            m_ack_prev <= 1'b0;
            m_busy     <= 1'b0;
            m_wait_low <= 1'b0;
            m_cause    <= 0;
            m_pend     <= '0;
            m_ovf      <= '0;
        end else begin
            tick  = bus.timer_en && (m_cnt == P - 1);
            m_cnt <= bus.timer_en ? (m_cnt + 1) % P : 0;
            ev = bus.src;
            if (tick) ev[N-1] = 1'b1;
            rise = bus.ack && !m_ack_prev;
            m_ack_prev <= bus.ack;
            clr = '0;
            if (m_busy && rise) clr[m_cause] = 1'b1;
            req = m_pend & bus.mask;
            if (m_busy) begin
                if (rise) begin
                    m_busy     <= 1'b0;
                    m_wait_low <= 1'b1;
                end
            end else if (m_wait_low) begin
                if (!bus.ack) m_wait_low <= 1'b0;
            end else if (req != 0) begin
                nc = 0;
                for (int i = N - 1; i >= 0; i--) if (req[i]) nc = i;
                m_busy  <= 1'b1;
                m_cause <= nc;
            end
            m_ovf  <= (bus.ovf_clr ? '0 : m_ovf) | (ev & m_pend & ~clr);
            m_pend <= (m_pend & ~clr) | ev;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_irq", bus.irq, m_busy);
            if (m_busy) chk("model_cause", bus.cause, m_cause);
            chk("model_pending", bus.pending, m_pend);
            chk("model_ovf", bus.ovf, m_ovf);
        end
    end

    task automatic serve();
        bus.ack = 1'b1;
        repeat (2) @(negedge clk);
        bus.ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_irq(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.irq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int t_prev;
        bus.src      = '0;
        bus.mask     = '0;
        bus.timer_en = 1'b0;
        bus.ack      = 1'b1;
        bus.ovf_clr  = 1'b0;
        chk_en       = 1'b1;

        // Reset with ack held high, then release with ack still high
        repeat (3) @(negedge clk);
        chk("rst_irq", bus.irq, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("ackhi_irq", bus.irq, 0);
        chk("ackhi_pending", bus.pending, 0);

        // Single source, long ack
        bus.ack  = 1'b0;
        bus.mask = 4'b0011;
        @(negedge clk);
        bus.src = 4'b0010;
        @(negedge clk);
        bus.src = '0;
        chk("t2_pending", bus.pending, 4'b0010);
        chk("t2_irq_early", bus.irq, 0);
        @(negedge clk);
        chk("t2_irq", bus.irq, 1);
        chk("t2_cause", bus.cause, 1);
        bus.ack = 1'b1;
        @(negedge clk);
        chk("t2_retire_irq", bus.irq, 0);
        chk("t2_retire_pending", bus.pending, 0);
        repeat (7) @(negedge clk);
        chk("t2_hold_irq", bus.irq, 0);
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);

        // Two simultaneous sources: lowest first
        bus.mask = 4'b1111;
        bus.src  = 4'b0110;
        @(negedge clk);
        bus.src = '0;
        @(negedge clk);
        chk("t3_irq", bus.irq, 1);
        chk("t3_cause_first", bus.cause, 1);
        bus.ack = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_pending_left", bus.pending, 4'b0100);
        bus.ack = 1'b0;
        @(negedge clk);
        chk("t3_gap_irq", bus.irq, 0);
        @(negedge clk);
        chk("t3_irq_second", bus.irq, 1);
        chk("t3_cause_second", bus.cause, 2);
        serve();
        chk("t3_drained", bus.pending, 0);

        // Overflow, ovf_clr, and set-wins-over-retire
        bus.mask = 4'b0001;
        bus.src  = 4'b0001;
        @(negedge clk);
        bus.src = '0;
        repeat (2) @(negedge clk);
        bus.src = 4'b0001;
        @(negedge clk);
        bus.src = '0;
        chk("t4_ovf", bus.ovf, 4'b0001);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("t4_ovf_clr", bus.ovf, 0);
        chk("t4_irq_before_ack", bus.irq, 1);
        bus.ack = 1'b1;
        bus.src = 4'b0001;
        @(negedge clk);
        bus.src = '0;
        chk("t4_keep_pending", bus.pending, 4'b0001);
        chk("t4_keep_ovf", bus.ovf, 0);
        chk("t4_retire_irq", bus.irq, 0);
        bus.ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_rerequest", bus.irq, 1);
        chk("t4_recause", bus.cause, 0);
        serve();

        // Timer on the top source
        bus.mask     = 4'b1000;
        bus.timer_en = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_irq(25, ok);
            chk("t5_irq_seen", ok, 1);
            chk("t5_cause", bus.cause, 3);
            if (k > 0) chk("t5_period", cyc - t_prev, P);
            t_prev = cyc;
            serve();
        end
        bus.timer_en = 1'b0;
        repeat (3 * P) @(negedge clk);
        chk("t5_stopped_pending", bus.pending, 0);
        chk("t5_stopped_irq", bus.irq, 0);

        // Random traffic
        bus.timer_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            bus.src = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 31) == 0) bus.mask = N'($urandom);
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) bus.ack = ~bus.ack;
            bus.timer_en = ($urandom_range(0, 31) != 0);
        end
        bus.src      = '0;
        bus.ovf_clr  = 1'b0;
        bus.ack      = 1'b0;
        bus.timer_en = 1'b0;
        bus.mask     = 4'b1111;
        repeat (3) @(negedge clk);

        // Asynchronous reset while requesting
        bus.src = 4'b0001;
        @(negedge clk);
        bus.src = '0;
        @(negedge clk);
        chk("t6_irq_before", bus.irq, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_irq", bus.irq, 0);
        chk("t6_async_pending", bus.pending, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_after_irq", bus.irq, 0);
        chk("t6_after_pending", bus.pending, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
